// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Clocks per bit period; integer division truncates toward zero.
    function automatic int calc_baud_cnt_max(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data. Pointers carry one extra
// wrap bit so full and empty are distinguished without a separate counter.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // A write into a full FIFO is dropped even if a read frees a slot on the same edge.
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; each pointer advances independently on its accepted strobe.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge sys_clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from an internal byte FIFO. Queued bytes are
// sent back-to-back; a byte is popped on entry to START and held in the
// shift register for the whole frame.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | line high, waiting for the FIFO to become non-empty
//   START | start bit (tx=0) for one bit period
//   DATA  | data bits LSB first, one bit period each
//   STOP  | stop bit (tx=1); pops the next byte on its last clock
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int UART_BPS     = 9600,
    parameter int BAUD_CNT_MAX = calc_baud_cnt_max(CLK_FREQ, UART_BPS),
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [UART_DATA_W-1:0] pi_data,
    input  logic                   pi_flag,
    output logic                   full,
    output logic                   busy,
    output logic                   tx
);

    localparam int BAUD_W = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT_MAX - 1);

    uart_state_t            state_q;
    uart_state_t            state_d;
    logic [BAUD_W-1:0]      baud_q;
    logic [BAUD_W-1:0]      baud_d;
    logic [2:0]             bit_q;
    logic [2:0]             bit_d;
    logic [UART_DATA_W-1:0] shift_q;
    logic                   load;
    logic                   tx_d;
    logic                   tx_q;

    logic                   fifo_rd;
    logic [UART_DATA_W-1:0] fifo_data;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_avail;
    logic                   baud_last;

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wr_en   (pi_flag),
        .wr_data (pi_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_data),
        .full    (full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign fifo_avail = !fifo_empty && (fifo_count != '0);
    assign baud_last  = (baud_q == BAUD_LAST);
    assign busy       = (state_q != IDLE);
    assign tx         = tx_q;

    // Next-state, counter and pop decisions; the line level for the next
    // cycle is derived here so tx itself comes straight from a flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        load    = 1'b0;
        fifo_rd = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (fifo_avail) begin
                    fifo_rd = 1'b1;
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (fifo_avail) begin
                        fifo_rd = 1'b1;
                        load    = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    // State, counters, shift register and registered line output.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            if (load) shift_q <= fifo_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with BAUD_CNT_MAX=5 (50 kHz clock, 9600 bps).
// Time index t counts edges from the first write of each scenario; outputs
// are sampled 1 ns after each rising edge.
module tb_uart_tx_fifo;

    logic       sys_clk;
    logic       sys_rst;
    logic [7:0] pi_data;
    logic       pi_flag;
    logic       full;
    logic       busy;
    logic       tx;

    int n_cmp;
    int n_err;

    uart_tx_fifo #(
        .CLK_FREQ   (50_000),
        .UART_BPS   (9600),
        .FIFO_DEPTH (16)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .pi_data (pi_data),
        .pi_flag (pi_flag),
        .full    (full),
        .busy    (busy),
        .tx      (tx)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level at cycle i (0..49) of a frame carrying d.
    function automatic logic frame_bit(input logic [7:0] d, input int i);
        int b;
        b = i / 5;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return d[b-1];
    endfunction

    // Called in the first cycle of a start bit; ends in the last stop cycle.
    task automatic check_frame(input string tag, input logic [7:0] d);
        for (int i = 0; i < 50; i++) begin
            if (i > 0) tick();
            check(tag, {31'd0, tx}, {31'd0, frame_bit(d, i)});
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        sys_rst = 1'b1;
        pi_flag = 1'b0;
        pi_data = 8'h00;

        // Reset values
        tick();
        check("rst_tx_in_reset", {31'd0, tx}, 32'd1);
        tick();
        tick();
        sys_rst = 1'b0;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_tx_high", {31'd0, tx}, 32'd1);
        end

        // Single byte 0xA5
        pi_flag = 1'b1;
        pi_data = 8'hA5;
        tick();
        pi_flag = 1'b0;
        check("single_t0_tx", {31'd0, tx}, 32'd1);
        check("single_t0_busy", {31'd0, busy}, 32'd0);
        tick();
        check("single_t1_busy", {31'd0, busy}, 32'd1);
        check_frame("single_a5", 8'hA5);
        check("single_t50_busy", {31'd0, busy}, 32'd1);
        tick();
        check("single_t51_busy", {31'd0, busy}, 32'd0);
        check("single_t51_tx", {31'd0, tx}, 32'd1);
        for (int i = 0; i < 10; i++) tick();

        // Burst of 20 writes into a 16-deep FIFO: 17 contiguous frames
        for (int t = 0; t < 870; t++) begin
            logic exp_tx;
            pi_flag = (t < 20);
            pi_data = 8'(t);
            tick();
            if (t >= 1 && t <= 850)
                exp_tx = frame_bit(8'((t - 1) / 50), (t - 1) % 50);
            else
                exp_tx = 1'b1;
            check("burst_tx", {31'd0, tx}, {31'd0, exp_tx});
            if (t == 15)  check("burst_full_t15", {31'd0, full}, 32'd0);
            if (t == 16)  check("burst_full_t16", {31'd0, full}, 32'd1);
            if (t == 19)  check("burst_full_t19", {31'd0, full}, 32'd1);
            if (t == 50)  check("burst_full_t50", {31'd0, full}, 32'd1);
            if (t == 51)  check("burst_full_t51", {31'd0, full}, 32'd0);
            if (t == 850) check("burst_busy_t850", {31'd0, busy}, 32'd1);
            if (t == 851) check("burst_busy_t851", {31'd0, busy}, 32'd0);
        end
        pi_flag = 1'b0;

        // Reset during data bit 3 of the first of two queued frames
        for (int t = 0; t < 22; t++) begin
            pi_flag = (t <= 1);
            pi_data = (t == 0) ? 8'h3C : 8'h3D;
            tick();
        end
        pi_flag = 1'b0;
        check("midrst_bit3_tx", {31'd0, tx}, 32'd1);
        check("midrst_busy_before", {31'd0, busy}, 32'd1);
        #2;
        sys_rst = 1'b1;
        #1;
        check("midrst_async_tx", {31'd0, tx}, 32'd1);
        check("midrst_async_busy", {31'd0, busy}, 32'd0);
        check("midrst_async_full", {31'd0, full}, 32'd0);
        tick();
        tick();
        sys_rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            check("midrst_quiet", {30'd0, tx, busy}, 32'd2);
        end

        // Write landing on the final STOP clock with the FIFO otherwise empty
        pi_flag = 1'b1;
        pi_data = 8'h55;
        tick();
        pi_flag = 1'b0;
        tick();
        check_frame("stopb_first_55", 8'h55);
        pi_flag = 1'b1;
        pi_data = 8'h81;
        tick();
        pi_flag = 1'b0;
        check("stopb_t51_tx", {31'd0, tx}, 32'd1);
        check("stopb_t51_busy", {31'd0, busy}, 32'd0);
        tick();
        check("stopb_t52_busy", {31'd0, busy}, 32'd1);
        check_frame("stopb_81", 8'h81);
        tick();
        check("stopb_end_tx", {31'd0, tx}, 32'd1);
        check("stopb_end_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 5; i++) tick();

        // Write while full on the same edge as a pop: dropped, count 15
        for (int t = 0; t < 53; t++) begin
            pi_flag = (t <= 16) || (t == 51) || (t == 52);
            pi_data = 8'(8'h40 + t);
            tick();
            if (t == 15) check("conc_full_t15", {31'd0, full}, 32'd0);
            if (t == 16) check("conc_full_t16", {31'd0, full}, 32'd1);
            if (t == 50) check("conc_full_t50", {31'd0, full}, 32'd1);
            if (t == 51) check("conc_full_t51", {31'd0, full}, 32'd0);
            if (t == 52) check("conc_full_t52", {31'd0, full}, 32'd1);
        end
        pi_flag = 1'b0;
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        tick();
        check("final_full", {31'd0, full}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

UART transmitter with an internal byte FIFO: the send-side counterpart to the 8N1 UART receive path in the `fifo_sum` datapath. It accepts byte write strobes from core logic, buffers them, and serialises each byte onto `tx`. Frames are 1 start bit, 8 data bits LSB first, and 1 stop bit. Queued bytes go out back-to-back with no idle gap between frames.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `UART_BPS`, default 9600: baud rate.
- `BAUD_CNT_MAX`, default CLK_FREQ/UART_BPS (integer division, 5208 at defaults): clocks per bit.
- `FIFO_DEPTH`, default 16: buffered bytes; must be a power of 2, ≥2.
- `sys_clk` (in, 1): system clock, all logic on the rising edge.
- `sys_rst` (in, 1): asynchronous, active-high reset.
- `pi_data` (in, 8): byte to send; sampled when `pi_flag`=1.
- `pi_flag` (in, 1): single-cycle write strobe.
- `full` (out, 1): FIFO holds FIFO_DEPTH bytes.
- `busy` (out, 1): a frame is in progress.
- `tx` (out, 1): serial line, idle high.

## Operation
- **Write acceptance:** a write is accepted iff `pi_flag`=1 and `full`=0 before the edge.
  - A write while `full`=1 is silently dropped, even if a pop happens in the same cycle.
- **Pop rule:** the FIFO is popped only by the FSM, and never while empty.
  - A write and a pop in the same cycle are both honoured; the count is unchanged.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `tx`=1, `busy`=0. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for BAUD_CNT_MAX clocks, then go to DATA with bit index 0.
  - DATA: `tx`=shift[bit_idx] for BAUD_CNT_MAX clocks per bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for BAUD_CNT_MAX clocks. On the last STOP clock:
    - if the FIFO is non-empty, pop and go directly to START (contiguous frames);
    - otherwise go to IDLE.
- **Baud counter:** width is clog2(BAUD_CNT_MAX). It counts 0..BAUD_CNT_MAX-1, clears on every state change, and wraps within DATA at each bit boundary.
- **Bit index:** 3 bits, 0..7.
- **Register and data rules:** `tx` is registered, with no combinational path from the FSM. The stored data byte is held unchanged for the whole frame.
- **Reset (asynchronous, any time, including mid-frame):**
  - `tx`=1, `busy`=0, `full`=0.
  - FSM goes to IDLE; FIFO pointers and count go to 0; counters go to 0.
  - The partial frame is abandoned and is not resent after reset.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `full`=0.
- **Latency:** write to an empty FIFO with the FSM in IDLE, sampled at edge k:
  - the FIFO becomes non-empty after edge k;
  - the pop happens at edge k+1;
  - `tx` falls and `busy` rises after edge k+1.
- **Frame length:** exactly 10·BAUD_CNT_MAX clocks, from `tx` falling to the end of the stop bit.
- **Back-to-back frames:** the next start bit begins the clock after the last stop clock.
- **Status timing:** `full` updates the cycle after the write that fills the FIFO, and clears the cycle after the pop that frees a slot.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state enum (IDLE/START/DATA/STOP);
  - constant UART_DATA_W=8;
  - function computing BAUD_CNT_MAX from CLK_FREQ and UART_BPS.
  - The UART receiver shares this package.
- **Sub-module `sync_fifo`:** parameterised width and depth, with write/read strobes, `full`/`empty`, and a count.
  - Pointers are clog2(DEPTH)+1 bits wide; full/empty are determined from the MSB compare.
- **Top-level contents:** FSM, baud counter, bit index, and shift register.

## Test plan
Bench overrides CLK_FREQ=50_000, UART_BPS=9600, giving BAUD_CNT_MAX=5.
- **Reset values:** assert `sys_rst` for 3 clocks, then release -> `tx`=1, `busy`=0, `full`=0; `tx` stays high for 100 clocks with no writes.
- **Single byte:** write 0xA5 at edge k ->
  - `tx` falls after edge k+1;
  - sampled mid-bit: 0, then 1,0,1,0,0,1,0,1, then 1;
  - each bit lasts 5 clocks;
  - `busy` drops after 50 clocks.
- **Burst with overflow:** write 0x00..0x13 on 20 consecutive clocks with FIFO_DEPTH=16 ->
  - `full` rises after the 17th write;
  - bytes 0x11..0x13 are dropped;
  - exactly 17 contiguous frames carry 0x00..0x10 in order;
  - no idle clocks between frames.
- **Reset mid-frame:** write 0x3C, 0x3D; assert `sys_rst` during bit 3 of the first frame ->
  - `tx`=1 immediately (asynchronous);
  - after release, no frame is ever emitted.
- **Write at stop boundary:** write 0x81 on the final STOP clock of a frame with the FIFO otherwise empty ->
  - the FSM goes to IDLE;
  - 0x81's start bit begins 1 clock later;
  - the frame decodes as 0x81.
- **Concurrent write and pop:** with the FIFO full, write a byte on the same clock the FSM pops -> the write is dropped, the count becomes FIFO_DEPTH-1, and `full` clears next cycle.
